msg_router_n: RTL and testbench
===============================

# msg_router_n

Parametrised N-channel successor to the two-channel message router: parses the serial byte stream (sync, ID, byte count, sequence number, payload) itself, routes payload bytes to one of NUM_CH data RAMs by message ID, and generates its own per-channel RAM addresses. Adds what the two-channel router lacks: sync hunting, unknown-ID rejection, payload-length overflow protection and per-channel sequence-gap detection. Sits between the serial-to-parallel receiver and the per-message data RAMs and controller.

## Interface
- NUM_CH, 4: number of routed message channels (1..8).
- IDS, {16'd104,16'd103,16'd102,16'd101}: packed ID table; channel i matches IDS[16*i +: 16].
- SYNC, 16'hABCD: required sync word.
- MAX_DATA, 256: payload capacity in bytes of each channel RAM; ADDR_W = $clog2(MAX_DATA) is derived, not a parameter.
- Clock  in  1  system clock; all logic on rising edge.
- Clear  in  1  reset, asynchronous, active-high.
- MessageByte  in  8  received byte.
- MessageByteReady  in  1  one-cycle strobe; MessageByte valid this cycle; may be asserted every cycle.
- MessageID, ByteCount, SequenceNumber  out  16 each  header fields of the current/last message; held until the next header completes.
- DataByte  out  8  payload byte for RAM write.
- DataAddr  out  ADDR_W  RAM address of DataByte, 0-based within the message.
- WriteCh  out  NUM_CH  one-hot write strobe.
- ClearCh  out  NUM_CH  one-hot pulse at header end (new message starting).
- CompleteCh  out  NUM_CH  one-hot pulse, message fully written.
- UnknownID, Overflow, SeqGap  out  1 each  single-cycle error pulses.

## Operation
- All header fields are big-endian (high byte first). Header = SYNC(2), ID(2), ByteCount(2), Seq(2); ByteCount = payload bytes following the header.
- States: HUNT_HI, HUNT_LO, HDR, DATA. Transitions occur only on MessageByteReady.
- HUNT_HI: byte == SYNC[15:8] -> HUNT_LO. HUNT_LO: byte == SYNC[7:0] -> HDR; else if byte == SYNC[15:8], stay in HUNT_LO; else -> HUNT_HI.
- HDR: 6-byte counter loads ID, ByteCount, Seq. On the 6th byte the ID is matched against IDS (lowest index wins on duplicates):
  - Match on channel k, ByteCount <= MAX_DATA: ClearCh[k] pulses. ByteCount > 0 -> DATA; ByteCount == 0 -> CompleteCh[k] pulses the following cycle, then HUNT_HI.
  - Match, ByteCount > MAX_DATA: Overflow pulses; payload is consumed without writes and without Complete.
  - No match: UnknownID pulses; payload is consumed silently.
  - In all three cases the header outputs update.
- Sequence check, matched channel only: a per-channel LastSeq/Valid pair is kept. If Valid and Seq != LastSeq+1 (mod 2^16), SeqGap pulses together with ClearCh. LastSeq <= Seq and Valid <= 1 regardless. Reset clears all Valid bits.
- DATA: each byte -> DataByte and DataAddr = payload index; WriteCh[k] pulses (suppressed for unknown/overflow). After ByteCount bytes -> HUNT_HI; CompleteCh[k] pulses one cycle after the last WriteCh.
- Clear asserted at any time: immediately HUNT_HI; all outputs and counters 0; Valid bits cleared. A partial message is abandoned with no Complete.

## Timing
- Reset values: every output 0, state HUNT_HI.
- All outputs are registered. ClearCh, WriteCh, DataByte/DataAddr and the error pulses appear exactly 1 cycle after the MessageByteReady cycle of the causing byte.
- CompleteCh appears 2 cycles after the last byte's ready (1 cycle after the last write).
- Strobes are single-cycle; at most one bit of any one-hot vector is set. A CompleteCh pulse may coincide with a ClearCh for the next message on another channel.
- Back-to-back bytes sustain one write per cycle; no stalls, no input handshake.

## Structure
- Package msg_router_pkg holds the state enum, header length constant (8), and header byte-index constants.
- Sub-module msg_header_parser: sync hunt plus header field capture, emitting HeaderDone. The top adds ID match, payload counter, sequence table and strobes.

## Test plan
- Sync ABCD, ID 102, count 3, seq 5, bytes 11 22 33 -> ClearCh=0010; WriteCh[1] at addr 0,1,2 with 11,22,33; CompleteCh[1] 1 cycle after the last write.
- Garbage AB AB CD then a valid header -> lock on the second AB; message routed normally.
- ID 200, count 2 -> UnknownID pulse, no strobes; the following valid message is still routed.
- ID 101, count 257 (MAX_DATA 256) -> Overflow, no writes/Complete, parser resyncs after 257 bytes; count 0 -> ClearCh then CompleteCh, no writes.
- ID 103 seq 7 then seq 9 -> SeqGap on the second header; seq FFFF then 0000 -> no SeqGap.
- Clear mid-payload -> outputs 0 asynchronously, no Complete; seq check after reset produces no SeqGap.

Source files
------------

// File: rtl/msg_router_pkg.sv
// Shared types and constants for the N-channel message router.
package msg_router_pkg;

    // Receive-side framing state
    typedef enum logic [1:0] {
        ST_HUNT_HI = 2'd0,
        ST_HUNT_LO = 2'd1,
        ST_HDR     = 2'd2,
        ST_DATA    = 2'd3
    } rx_state_e;

    // Header is SYNC(2) ID(2) COUNT(2) SEQ(2), big-endian
    localparam int HDR_LEN = 8;

    // Byte positions within the header (sync occupies 0 and 1)
    localparam logic [2:0] IDX_ID_HI  = 3'd2;
    localparam logic [2:0] IDX_ID_LO  = 3'd3;
    localparam logic [2:0] IDX_CNT_HI = 3'd4;
    localparam logic [2:0] IDX_CNT_LO = 3'd5;
    localparam logic [2:0] IDX_SEQ_HI = 3'd6;
    localparam logic [2:0] IDX_SEQ_LO = 3'(HDR_LEN - 1);

    // True when seq does not directly follow last (16-bit wrap-around)
    function automatic logic seq_is_gap(input logic [15:0] last, input logic [15:0] seq);
        logic [15:0] nxt;
        nxt = last + 16'd1;
        return (seq != nxt);
    endfunction

endpackage

// File: rtl/msg_header_parser.sv
// Sync hunt and header capture; reports the final header byte as hdr_done_o
// together with the complete ID/count/sequence fields in that same cycle.
module msg_header_parser
    import msg_router_pkg::*;
#(
    parameter logic [15:0] SYNC = 16'hABCD
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [7:0]  msg_byte_i,
    input  logic        byte_ready_i,
    input  logic        data_last_i,
    output logic        hdr_done_o,
    output logic        in_data_o,
    output logic [15:0] id_o,
    output logic [15:0] count_o,
    output logic [15:0] seq_o
);
    localparam logic [7:0] SYNC_HI = SYNC[15:8];
    localparam logic [7:0] SYNC_LO = SYNC[7:0];

    rx_state_e   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] id_q, id_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  seq_hi_q, seq_hi_d;
    logic        last_hdr_byte_s;

    assign last_hdr_byte_s = byte_ready_i && (state_q == ST_HDR) && (idx_q == IDX_SEQ_LO);

    // State register
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= ST_HUNT_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: every transition is qualified by a received byte
    always_comb begin
        state_d = state_q;
        if (byte_ready_i) begin
            case (state_q)
                ST_HUNT_HI: begin
                    if (msg_byte_i == SYNC_HI) state_d = ST_HUNT_LO;
                    else                       state_d = ST_HUNT_HI;
                end
                ST_HUNT_LO: begin
                    // A repeated high sync byte may itself start the real sync
                    if (msg_byte_i == SYNC_LO)      state_d = ST_HDR;
                    else if (msg_byte_i == SYNC_HI) state_d = ST_HUNT_LO;
                    else                            state_d = ST_HUNT_HI;
                end
                ST_HDR: begin
                    if (idx_q == IDX_SEQ_LO) state_d = (count_q != 16'd0) ? ST_DATA : ST_HUNT_HI;
                    else                     state_d = ST_HDR;
                end
                ST_DATA: begin
                    if (data_last_i) state_d = ST_HUNT_HI;
                    else             state_d = ST_DATA;
                end
                default: state_d = ST_HUNT_HI;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Header byte index and field capture next-state
    always_comb begin
        idx_d    = idx_q;
        id_d     = id_q;
        count_d  = count_q;
        seq_hi_d = seq_hi_q;
        if (byte_ready_i && (state_q == ST_HUNT_LO) && (msg_byte_i == SYNC_LO)) begin
            idx_d = IDX_ID_HI;
        end else if (byte_ready_i && (state_q == ST_HDR)) begin
            idx_d = idx_q + 3'd1;
            case (idx_q)
                IDX_ID_HI:  id_d[15:8]    = msg_byte_i;
                IDX_ID_LO:  id_d[7:0]     = msg_byte_i;
                IDX_CNT_HI: count_d[15:8] = msg_byte_i;
                IDX_CNT_LO: count_d[7:0]  = msg_byte_i;
                IDX_SEQ_HI: seq_hi_d      = msg_byte_i;
                default:    seq_hi_d      = seq_hi_q;
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    // Header field registers
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            idx_q    <= 3'd0;
            id_q     <= 16'd0;
            count_q  <= 16'd0;
            seq_hi_q <= 8'd0;
        end else begin
            idx_q    <= idx_d;
            id_q     <= id_d;
            count_q  <= count_d;
            seq_hi_q <= seq_hi_d;
        end
    end

    // Outputs: the sequence low byte is the byte arriving with hdr_done_o
    always_comb begin
        hdr_done_o = last_hdr_byte_s;
        in_data_o  = (state_q == ST_DATA);
        id_o       = id_q;
        count_o    = count_q;
        seq_o      = {seq_hi_q, msg_byte_i};
    end

endmodule

// File: rtl/msg_router_n.sv
// N-channel message router: ID match, payload addressing, per-channel
// sequence tracking and registered one-hot strobes.
module msg_router_n
    import msg_router_pkg::*;
#(
    parameter int                    NUM_CH   = 4,
    parameter logic [16*NUM_CH-1:0]  IDS      = {16'd104, 16'd103, 16'd102, 16'd101},
    parameter logic [15:0]           SYNC     = 16'hABCD,
    parameter int                    MAX_DATA = 256,
    localparam int                   ADDR_W   = $clog2(MAX_DATA)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [7:0]        MessageByte,
    input  logic              MessageByteReady,
    output logic [15:0]       MessageID,
    output logic [15:0]       ByteCount,
    output logic [15:0]       SequenceNumber,
    output logic [7:0]        DataByte,
    output logic [ADDR_W-1:0] DataAddr,
    output logic [NUM_CH-1:0] WriteCh,
    output logic [NUM_CH-1:0] ClearCh,
    output logic [NUM_CH-1:0] CompleteCh,
    output logic              UnknownID,
    output logic              Overflow,
    output logic              SeqGap
);
    localparam logic [16:0] MAX_DATA_W = 17'(MAX_DATA);

    logic        hdr_done_s, in_data_s, data_fire_s, data_last_s;
    logic [15:0] hdr_id_s, hdr_count_s, hdr_seq_s;
    logic        match_s, count_ok_s, gap_s;
    logic [2:0]  match_idx_s;
    logic [NUM_CH-1:0] match_oh_s;

    logic [15:0]       msg_id_q, msg_id_d, byte_cnt_q, byte_cnt_d, seq_num_q, seq_num_d;
    logic [15:0]       pay_cnt_q, pay_cnt_d;
    logic [7:0]        data_byte_q, data_byte_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [NUM_CH-1:0] write_ch_q, write_ch_d, clear_ch_q, clear_ch_d;
    logic [NUM_CH-1:0] complete_ch_q, complete_ch_d, cmpl_pend_q, cmpl_pend_d;
    logic [NUM_CH-1:0] act_oh_q, act_oh_d;
    logic              wr_en_q, wr_en_d;
    logic              unknown_q, unknown_d, overflow_q, overflow_d, seq_gap_q, seq_gap_d;
    logic [7:0]        seq_valid_q, seq_valid_d;
    logic [127:0]      last_seq_q, last_seq_d;

    msg_header_parser #(.SYNC(SYNC)) u_parser (
        .Clock        (Clock),
        .Clear        (Clear),
        .msg_byte_i   (MessageByte),
        .byte_ready_i (MessageByteReady),
        .data_last_i  (data_last_s),
        .hdr_done_o   (hdr_done_s),
        .in_data_o    (in_data_s),
        .id_o         (hdr_id_s),
        .count_o      (hdr_count_s),
        .seq_o        (hdr_seq_s)
    );

    assign data_fire_s = in_data_s && MessageByteReady;
    assign data_last_s = (pay_cnt_q == (byte_cnt_q - 16'd1));

    // ID lookup; scanning downward lets the lowest matching index win
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hdr_id_s == IDS[16*i +: 16]) begin
                match_s     = 1'b1;
                match_idx_s = 3'(i);
            end else begin
                match_s     = match_s;
            end
        end
        match_oh_s = NUM_CH'(1'b1) << match_idx_s;
        count_ok_s = ({1'b0, hdr_count_s} <= MAX_DATA_W);
        gap_s      = seq_valid_q[match_idx_s] &&
                     seq_is_gap(last_seq_q[16*match_idx_s +: 16], hdr_seq_s);
    end

    // Next-state for header outputs, payload addressing, sequence table and strobes
    always_comb begin
        msg_id_d      = msg_id_q;
        byte_cnt_d    = byte_cnt_q;
        seq_num_d     = seq_num_q;
        pay_cnt_d     = pay_cnt_q;
        data_byte_d   = data_byte_q;
        data_addr_d   = data_addr_q;
        act_oh_d      = act_oh_q;
        wr_en_d       = wr_en_q;
        seq_valid_d   = seq_valid_q;
        last_seq_d    = last_seq_q;
        write_ch_d    = {NUM_CH{1'b0}};
        clear_ch_d    = {NUM_CH{1'b0}};
        unknown_d     = 1'b0;
        overflow_d    = 1'b0;
        seq_gap_d     = 1'b0;
        // Completion is always reported one cycle after its cause
        complete_ch_d = cmpl_pend_q;
        cmpl_pend_d   = {NUM_CH{1'b0}};
        if (hdr_done_s) begin
            msg_id_d   = hdr_id_s;
            byte_cnt_d = hdr_count_s;
            seq_num_d  = hdr_seq_s;
            pay_cnt_d  = 16'd0;
            if (match_s) begin
                seq_valid_d[match_idx_s]          = 1'b1;
                last_seq_d[16*match_idx_s +: 16]  = hdr_seq_s;
                if (count_ok_s) begin
                    clear_ch_d = match_oh_s;
                    seq_gap_d  = gap_s;
                    act_oh_d   = match_oh_s;
                    wr_en_d    = 1'b1;
                    if (hdr_count_s == 16'd0) cmpl_pend_d = match_oh_s;
                    else                      cmpl_pend_d = {NUM_CH{1'b0}};
                end else begin
                    // Oversized payload is drained without touching the RAM
                    overflow_d = 1'b1;
                    wr_en_d    = 1'b0;
                end
            end else begin
                unknown_d = 1'b1;
                wr_en_d   = 1'b0;
            end
        end else if (data_fire_s) begin
            pay_cnt_d = pay_cnt_q + 16'd1;
            if (wr_en_q) begin
                write_ch_d  = act_oh_q;
                data_byte_d = MessageByte;
                data_addr_d = pay_cnt_q[ADDR_W-1:0];
                if (data_last_s) cmpl_pend_d = act_oh_q;
                else             cmpl_pend_d = {NUM_CH{1'b0}};
            end else begin
                write_ch_d = {NUM_CH{1'b0}};
            end
        end else begin
            pay_cnt_d = pay_cnt_q;
        end
    end

    // Output and bookkeeping registers
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            msg_id_q      <= 16'd0;
            byte_cnt_q    <= 16'd0;
            seq_num_q     <= 16'd0;
            pay_cnt_q     <= 16'd0;
            data_byte_q   <= 8'd0;
            data_addr_q   <= {ADDR_W{1'b0}};
            act_oh_q      <= {NUM_CH{1'b0}};
            wr_en_q       <= 1'b0;
            seq_valid_q   <= 8'd0;
            last_seq_q    <= 128'd0;
            write_ch_q    <= {NUM_CH{1'b0}};
            clear_ch_q    <= {NUM_CH{1'b0}};
            complete_ch_q <= {NUM_CH{1'b0}};
            cmpl_pend_q   <= {NUM_CH{1'b0}};
            unknown_q     <= 1'b0;
            overflow_q    <= 1'b0;
            seq_gap_q     <= 1'b0;
        end else begin
            msg_id_q      <= msg_id_d;
            byte_cnt_q    <= byte_cnt_d;
            seq_num_q     <= seq_num_d;
            pay_cnt_q     <= pay_cnt_d;
            data_byte_q   <= data_byte_d;
            data_addr_q   <= data_addr_d;
            act_oh_q      <= act_oh_d;
            wr_en_q       <= wr_en_d;
            seq_valid_q   <= seq_valid_d;
            last_seq_q    <= last_seq_d;
            write_ch_q    <= write_ch_d;
            clear_ch_q    <= clear_ch_d;
            complete_ch_q <= complete_ch_d;
            cmpl_pend_q   <= cmpl_pend_d;
            unknown_q     <= unknown_d;
            overflow_q    <= overflow_d;
            seq_gap_q     <= seq_gap_d;
        end
    end

    assign MessageID      = msg_id_q;
    assign ByteCount      = byte_cnt_q;
    assign SequenceNumber = seq_num_q;
    assign DataByte       = data_byte_q;
    assign DataAddr       = data_addr_q;
    assign WriteCh        = write_ch_q;
    assign ClearCh        = clear_ch_q;
    assign CompleteCh     = complete_ch_q;
    assign UnknownID      = unknown_q;
    assign Overflow       = overflow_q;
    assign SeqGap         = seq_gap_q;

endmodule

// File: tb/tb_msg_router_n.sv
// Scoreboard bench for msg_router_n: stimulus queues expected strobe events
// with their due cycle; a negedge monitor pops and compares them.
module tb_msg_router_n;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [7:0]  MessageByte;
    logic        MessageByteReady;
    logic [15:0] MessageID, ByteCount, SequenceNumber;
    logic [7:0]  DataByte;
    logic [7:0]  DataAddr;
    logic [3:0]  WriteCh, ClearCh, CompleteCh;
    logic        UnknownID, Overflow, SeqGap;

    msg_router_n dut (
        .Clock            (Clock),
        .Clear            (Clear),
        .MessageByte      (MessageByte),
        .MessageByteReady (MessageByteReady),
        .MessageID        (MessageID),
        .ByteCount        (ByteCount),
        .SequenceNumber   (SequenceNumber),
        .DataByte         (DataByte),
        .DataAddr         (DataAddr),
        .WriteCh          (WriteCh),
        .ClearCh          (ClearCh),
        .CompleteCh       (CompleteCh),
        .UnknownID        (UnknownID),
        .Overflow         (Overflow),
        .SeqGap           (SeqGap)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  wr, clr, cmp;
        logic        unk, ovf, gap;
        logic [7:0]  data, addr;
        logic        hdr;
        logic [15:0] id, cnt, seq;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    ev_t         me;
    logic [14:0] obs;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every cycle's strobes against the scoreboard head
    always @(negedge Clock) begin
        if (mon_en && !Clear) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < 32'(cyc)) begin
                chk("missed_event_due_cycle", 32'(cyc), exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            obs = {WriteCh, ClearCh, CompleteCh, UnknownID, Overflow, SeqGap};
            if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
                me = exp_q.pop_front();
                chk("strobes", 32'(obs), 32'({me.wr, me.clr, me.cmp, me.unk, me.ovf, me.gap}));
                if (me.wr != 4'd0) begin
                    chk("data_byte", 32'(DataByte), 32'(me.data));
                    chk("data_addr", 32'(DataAddr), 32'(me.addr));
                end
                if (me.hdr) begin
                    chk("msg_id", 32'(MessageID), 32'(me.id));
                    chk("byte_count", 32'(ByteCount), 32'(me.cnt));
                    chk("seq_num", 32'(SequenceNumber), 32'(me.seq));
                end
            end else if (obs != 15'd0) begin
                chk("unexpected_strobes", 32'(obs), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int k);
        @(negedge Clock);
        MessageByte      = b;
        MessageByteReady = 1'b1;
        k                = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clock);
            MessageByteReady = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_id"},  32'(MessageID), 32'd0);
        chk({tag, "_cnt"}, 32'(ByteCount), 32'd0);
        chk({tag, "_seq"}, 32'(SequenceNumber), 32'd0);
        chk({tag, "_rest"}, 32'({DataByte, DataAddr, WriteCh, ClearCh, CompleteCh,
                                 UnknownID, Overflow, SeqGap}), 32'd0);
    endtask

    // Sends one message (n_pay payload bytes d0, d0+step, ...) and queues
    // the hand-specified expectation: routed channel (or -1) and error pulses.
    task automatic send_msg(input logic [15:0] id, input logic [15:0] cnt, input logic [15:0] seq,
                            input logic [7:0] d0, input logic [7:0] step, input int n_pay,
                            input int exp_ch, input bit exp_unk, input bit exp_ovf,
                            input bit exp_gap, input bit with_sync);
        int         k;
        ev_t        e;
        logic [3:0] oh;
        oh = (exp_ch >= 0) ? (4'b0001 << exp_ch) : 4'b0000;
        if (with_sync) begin
            send_byte(8'hAB, k);
            send_byte(8'hCD, k);
        end
        send_byte(id[15:8], k);
        send_byte(id[7:0], k);
        send_byte(cnt[15:8], k);
        send_byte(cnt[7:0], k);
        send_byte(seq[15:8], k);
        send_byte(seq[7:0], k);
        e = '0; e.cyc = 32'(k + 1); e.clr = oh; e.unk = exp_unk; e.ovf = exp_ovf;
        e.gap = exp_gap; e.hdr = 1'b1; e.id = id; e.cnt = cnt; e.seq = seq;
        exp_q.push_back(e);
        if (oh != 4'd0 && cnt == 16'd0) begin
            e = '0; e.cyc = 32'(k + 2); e.cmp = oh;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n_pay; i++) begin
            send_byte(d0 + 8'(i) * step, k);
            if (oh != 4'd0) begin
                e = '0; e.cyc = 32'(k + 1); e.wr = oh; e.data = d0 + 8'(i) * step; e.addr = 8'(i);
                exp_q.push_back(e);
                if (i == int'(cnt) - 1) begin
                    e = '0; e.cyc = 32'(k + 2); e.cmp = oh;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        int k;
        Clear            = 1'b1;
        MessageByte      = 8'd0;
        MessageByteReady = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge Clock);
        Clear  = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Basic routing: ID 102 -> channel 1, payload 11 22 33
        send_msg(16'd102, 16'd3, 16'd5, 8'h11, 8'h11, 3, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // Garbage then AB AB CD: lock on the second AB
        send_byte(8'h00, k); send_byte(8'hAB, k); send_byte(8'h12, k);
        send_byte(8'hAB, k); send_byte(8'hAB, k); send_byte(8'hCD, k);
        send_msg(16'd104, 16'd2, 16'h0010, 8'h40, 8'h01, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        // Unknown ID consumed silently, next message still routed
        send_msg(16'd200, 16'd2, 16'd1, 8'hAB, 8'h22, 2, -1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_msg(16'd103, 16'd1, 16'd7, 8'h77, 8'h01, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        // Sequence gap 7 -> 9, then FFFF (gap after 0010) -> 0000 wraps cleanly
        send_msg(16'd103, 16'd2, 16'd9, 8'h90, 8'h01, 2, 2, 1'b0, 1'b0, 1'b1, 1'b1);
        send_msg(16'd104, 16'd1, 16'hFFFF, 8'hF0, 8'h01, 1, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        send_msg(16'd104, 16'd1, 16'h0000, 8'h0A, 8'h01, 1, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        // Overflow: 257 bytes drained without writes, then resync
        send_msg(16'd101, 16'd257, 16'd0, 8'h00, 8'h01, 257, -1, 1'b0, 1'b1, 1'b0, 1'b1);
        // Zero-length message: ClearCh then CompleteCh, no writes
        send_msg(16'd101, 16'd0, 16'd1, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Back-to-back follow-up
        send_msg(16'd102, 16'd4, 16'd6, 8'hC0, 8'h03, 4, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Clear mid-payload: no Complete, everything zeroed asynchronously
        send_msg(16'd103, 16'd5, 16'd10, 8'h50, 8'h01, 2, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("pre_clear_id", 32'(MessageID), 32'd103);
        #2;
        Clear = 1'b1;
        #1;
        check_all_zero("async_clear");
        chk("queue_empty_after_clear", 32'(exp_q.size()), 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Clear = 1'b0;
        idle(2);
        // Sequence history forgotten after reset: no gap
        send_msg(16'd103, 16'd1, 16'd50, 8'h33, 8'h01, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
